// File: rtl/definesPkg.sv
// definesPkg: shared AHB-Lite definitions for the memory slave.
//   - default bus widths (ADDRESS_WIDTH, DATA_WIDTH) and field widths
//   - HTRANS encodings (IDLE/BUSY/NON_SEQ/SEQ), HRESP values, HSIZE encodings
//   - ahb_slv_state_e: data-phase FSM states of ahb_memory_slave
package definesPkg;

  localparam int ADDRESS_WIDTH  = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int HSIZE_WIDTH    = 3;
  localparam int BURST_WIDTH    = 3;
  localparam int TRANSFER_WIDTH = 2;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] BUSY    = 2'b01;
  localparam logic [1:0] NON_SEQ = 2'b10;
  localparam logic [1:0] SEQ     = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_WAIT  = 2'd1,
    S_ERR1  = 2'd2,
    S_ERR2  = 2'd3
  } ahb_slv_state_e;

endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: DEPTH x DATA_W word storage.
//   clk            : clock
//   wr_en / wr_idx : write strobe and word index
//   wr_be          : byte-lane enables (bit b enables wr_data[8*b +: 8])
//   wr_data        : write word
//   rd_idx         : read word index (combinational read)
//   rd_data        : full word at rd_idx
// Contents are intentionally not reset.
module ahb_mem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/ahb_memory_slave.sv
// ahb_memory_slave: AHB-Lite memory slave with byte-enabled storage,
// read-only region (two-cycle ERROR response) and optional wait states.
//
// Ports:
//   HCLK, HRESET (synchronous, active-high)
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA : master request
//   HRDATA, HREADY, HRESP                               : slave response
//
// Build option: define AHB_MEM_WAIT_EN to build the wait counter and the
// S_WAIT state; WAIT_STATES (0..15) is then inserted per OKAY data phase.
// Without it every OKAY transfer is zero-wait.
//
// Handshake: an address phase is accepted on a rising edge where HSEL=1,
// HREADY=1 and HTRANS is NON_SEQ/SEQ. Its data phase ends on the first
// following edge where HREADY=1; a write commits on that edge, and a read
// presents its word on HRDATA during the HREADY=1 cycle. HBURST is
// informational only: every beat is decoded as an independent transfer.
// DEPTH is expected to be a power of two.
module ahb_memory_slave
  import definesPkg::*;
#(
  parameter int unsigned ADDR_W      = ADDRESS_WIDTH,
  parameter int unsigned DATA_W      = DATA_WIDTH,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned RO_BASE     = 0,
  parameter int unsigned RO_LIMIT    = 0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic                      HWRITE,
  input  logic [HSIZE_WIDTH-1:0]    HSIZE,
  input  logic [BURST_WIDTH-1:0]    HBURST,
  input  logic [TRANSFER_WIDTH-1:0] HTRANS,
  input  logic [DATA_W-1:0]         HWDATA,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADY,
  output logic                      HRESP
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RO_BASE_A = ADDR_W'(RO_BASE);
  localparam logic [ADDR_W-1:0] RO_SPAN   = ADDR_W'(RO_LIMIT - RO_BASE);
  localparam bit                RO_EN     = (RO_LIMIT >= RO_BASE);

  ahb_slv_state_e    state_q, state_d;
  logic              wr_pend_q, wr_pend_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [NB-1:0]     wr_mask_q, wr_mask_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

`ifdef AHB_MEM_WAIT_EN
  logic [3:0] wcnt_q, wcnt_d;
`else
  logic [3:0] unused_wait_states;
  assign unused_wait_states = 4'(WAIT_STATES);
`endif

  logic unused_burst;
  assign unused_burst = ^HBURST;

  // Address-phase decode
  logic [IW-1:0]     req_idx;
  logic [NB-1:0]     req_mask;
  int unsigned       off, nbytes;
  logic              size_ok, aligned, in_range, ro_hit, req_err;
  logic              accept, commit, fwd, mem_we;
  logic [DATA_W-1:0] rd_word, merged;

  assign req_idx = HADDR[IW+LB-1:LB];

  always_comb begin
    nbytes   = 32'd1 << HSIZE;
    off      = 32'(HADDR[LB-1:0]);
    req_mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      req_mask[b] = (b >= off) && (b < off + nbytes);
    end
    size_ok  = (32'(HSIZE) <= LB);
    aligned  = ((off & (nbytes - 32'd1)) == 32'd0);
    in_range = ((HADDR >> (IW + LB)) == '0);
    // Wrapping subtraction turns the [base, limit] test into one compare.
    ro_hit   = RO_EN && HWRITE && ((HADDR - RO_BASE_A) <= RO_SPAN);
    req_err  = !size_ok || !aligned || !in_range || ro_hit;
  end

  assign HREADY = (state_q == S_READY) || (state_q == S_ERR2);
  assign HRESP  = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = hrdata_q;

  assign accept = HSEL && HREADY && ((HTRANS == NON_SEQ) || (HTRANS == SEQ));
  assign commit = HREADY && wr_pend_q;
  // A reset edge must never complete the pending write.
  assign mem_we = commit && !HRESET;
  assign fwd    = commit && (wr_idx_q == req_idx);

  // Read-during-commit: new lanes from HWDATA over the stored word.
  always_comb begin
    merged = rd_word;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_mask_q[b]) merged[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_pend_d = wr_pend_q;
    wr_idx_d  = wr_idx_q;
    wr_mask_d = wr_mask_q;
    hrdata_d  = hrdata_q;
`ifdef AHB_MEM_WAIT_EN
    wcnt_d    = wcnt_q;
`endif

    if (commit) wr_pend_d = 1'b0;

    case (state_q)
      S_ERR1: state_d = S_ERR2;
`ifdef AHB_MEM_WAIT_EN
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) state_d = S_READY;
      end
`endif
      default: state_d = S_READY;
    endcase

    if (accept) begin
      if (req_err) begin
        // Errors skip wait states and never touch memory.
        state_d  = S_ERR1;
        hrdata_d = '0;
      end else begin
`ifdef AHB_MEM_WAIT_EN
        if (WAIT_STATES != 0) begin
          state_d = S_WAIT;
          wcnt_d  = 4'(WAIT_STATES);
        end else begin
          state_d = S_READY;
        end
`else
        state_d = S_READY;
`endif
        if (HWRITE) begin
          wr_pend_d = 1'b1;
          wr_idx_d  = req_idx;
          wr_mask_d = req_mask;
        end else begin
          hrdata_d = fwd ? merged : rd_word;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_READY;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_mask_q <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_mask_q <= wr_mask_d;
      hrdata_q  <= hrdata_d;
    end
  end

`ifdef AHB_MEM_WAIT_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) wcnt_q <= 4'd0;
    else        wcnt_q <= wcnt_d;
  end
`endif

  ahb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (HCLK),
    .wr_en   (mem_we),
    .wr_idx  (wr_idx_q),
    .wr_be   (wr_mask_q),
    .wr_data (HWDATA),
    .rd_idx  (req_idx),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_ahb_memory_slave.sv
// Testbench for ahb_memory_slave: directed scenarios plus random traffic,
// with a byte-level reference memory and an expected-response queue
// consumed by an independent bus monitor.
module tb_ahb_memory_slave;
  import definesPkg::*;

  localparam int          MEM_BYTES = 1024;   // DEPTH 256 x 4 bytes
  localparam logic [31:0] RO_B      = 32'h80;
  localparam logic [31:0] RO_L      = 32'hFF;
`ifdef AHB_MEM_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif
  // expected entry: {err, is_read, known_byte_mask[3:0], data[31:0]}
  localparam int EXP_W = 38;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;
  bit done = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       ref_mem [MEM_BYTES];
  bit               known   [MEM_BYTES];

  ahb_memory_slave #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH       (256),
    .RO_BASE     (32'h80),
    .RO_LIMIT    (32'hFF),
    .WAIT_STATES (2)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .HSEL   (HSEL),
    .HADDR  (HADDR),
    .HWRITE (HWRITE),
    .HSIZE  (HSIZE),
    .HBURST (HBURST),
    .HTRANS (HTRANS),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [31:0] addr, input bit wr,
                              input logic [2:0] size, input logic [31:0] wdata);
    int          nbytes;
    bit          err;
    int          base;
    logic [31:0] d;
    logic [3:0]  m;
    nbytes = 1 << size;
    err = (addr >= 32'(MEM_BYTES)) || (size > 3'd2) ||
          ((addr & 32'(nbytes - 1)) != 32'd0) ||
          (wr && addr >= RO_B && addr <= RO_L);
    d = '0;
    m = '0;
    if (err) begin
      exp_q.push_back({1'b1, !wr, 4'hF, 32'h0});
    end else begin
      base = int'(addr) & ~3;
      if (wr) begin
        for (int k = 0; k < nbytes; k++) begin
          int a;
          a = int'(addr) + k;
          ref_mem[a] = wdata[8*(a%4) +: 8];
          known[a]   = 1'b1;
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          d[8*b +: 8] = ref_mem[base + b];
          m[b]        = known[base + b];
        end
      end
      exp_q.push_back({1'b0, !wr, m, d});
    end
  endtask

  // ---------------- driver ----------------
  // Presents one address phase, waits for it to be taken, then drives the
  // write data for its data phase and parks HTRANS at IDLE.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [31:0] wdata,
                      input bit sel, input bit track);
    int n;
    HSEL   = sel;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = trans;
    n = 0;
    forever begin
      @(negedge HCLK);
      if (HREADY === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL drv_timeout: HREADY=%b, required 1 within 50 cycles (addr %h)", HREADY, addr);
        break;
      end
    end
    @(posedge HCLK);
    #1;
    if (sel && trans[1]) begin
      if (track) model_accept(addr, wr, size, wdata);
      if (wr) HWDATA = wdata;
    end
    HTRANS = IDLE;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit               in_phase = 0;
  bit               started = 0;
  int               low = 0;
  logic [EXP_W-1:0] cur;
  logic [31:0]      last_rd = '0;
  logic [31:0]      bm;

  initial begin : monitor
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_phase = 0;
        started  = 0;
        exp_q.delete();
        last_rd  = '0;
      end else begin
        if (in_phase) begin
          if (!started) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL exp_empty: data phase at %0t, required an expected entry", $time);
              in_phase = 0;
            end else begin
              cur     = exp_q.pop_front();
              started = 1;
              low     = 0;
            end
          end
          if (in_phase) begin
            checks++;
            if (HRESP !== cur[37]) begin
              errors++;
              $display("FAIL hresp: got %b, required %b at %0t", HRESP, cur[37], $time);
            end
            if (HREADY !== 1'b1) begin
              low++;
              if (low > 20) begin
                checks++;
                errors++;
                $display("FAIL hready_stuck: HREADY low %0d cycles, required <= %0d", low, WS);
                in_phase = 0;
              end
            end else begin
              checks++;
              if (low != (cur[37] ? 1 : WS)) begin
                errors++;
                $display("FAIL wait_cycles: got %0d low cycles, required %0d", low, cur[37] ? 1 : WS);
              end
              for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{cur[32+b]}};
              if (cur[37] || cur[36]) begin
                checks++;
                if ((HRDATA & bm) !== (cur[31:0] & bm)) begin
                  errors++;
                  $display("FAIL rdata: got %h, required %h (byte mask %h)", HRDATA, cur[31:0], bm);
                end
              end
              if (cur[37])      last_rd = '0;
              else if (cur[36]) last_rd = (cur[31:0] & bm) | (HRDATA & ~bm);
              in_phase = 0;
            end
          end
        end else begin
          checks++;
          if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp: HREADY=%b HRESP=%b, required 1/0 at %0t", HREADY, HRESP, $time);
          end
          checks++;
          if (HRDATA !== last_rd) begin
            errors++;
            $display("FAIL rdata_hold: got %h, required %h at %0t", HRDATA, last_rd, $time);
          end
        end
        if (HREADY === 1'b1 && HSEL && HTRANS[1]) begin
          in_phase = 1;
          started  = 0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL watchdog: stimulus incomplete at %0t, required completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    int          r;

    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;

    // Fill all writable words so later reads have known contents.
    for (int i = 0; i < MEM_BYTES; i += 4) begin
      if (32'(i) < RO_B || 32'(i) > RO_L) xfer(32'(i), 1, 3'd2, NON_SEQ, $urandom, 1, 1);
    end

    // Word write then read
    xfer(32'h10, 1, 3'd2, NON_SEQ, 32'hDEADBEEF, 1, 1);
    xfer(32'h10, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);
    // Byte write lane 1, then word read
    xfer(32'h11, 1, 3'd0, NON_SEQ, 32'h0000AB00, 1, 1);
    xfer(32'h10, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);
    // Read-only region: write errors, read returns prior contents
    xfer(32'h84, 1, 3'd2, NON_SEQ, 32'h12345678, 1, 1);
    xfer(32'h84, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);
    // INCR4 write with BUSY after beat 2, then INCR4 read back
    HBURST = 3'b011;
    xfer(32'h40, 1, 3'd2, NON_SEQ, 32'd1, 1, 1);
    xfer(32'h44, 1, 3'd2, SEQ,     32'd2, 1, 1);
    xfer(32'h48, 1, 3'd2, BUSY,    32'd0, 1, 1);
    xfer(32'h48, 1, 3'd2, SEQ,     32'd3, 1, 1);
    xfer(32'h4C, 1, 3'd2, SEQ,     32'd4, 1, 1);
    xfer(32'h40, 0, 3'd2, NON_SEQ, 32'd0, 1, 1);
    xfer(32'h44, 0, 3'd2, SEQ,     32'd0, 1, 1);
    xfer(32'h48, 0, 3'd2, SEQ,     32'd0, 1, 1);
    xfer(32'h4C, 0, 3'd2, SEQ,     32'd0, 1, 1);
    HBURST = 3'b000;
    // Forwarding: full word, then a halfword merged into a word read
    xfer(32'h20, 1, 3'd2, NON_SEQ, 32'hCAFEF00D, 1, 1);
    xfer(32'h20, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);
    xfer(32'h22, 1, 3'd1, NON_SEQ, 32'h1234_0000, 1, 1);
    xfer(32'h20, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);
    // Other error kinds: misaligned, too wide, out of range
    xfer(32'h13, 0, 3'd1, NON_SEQ, 32'h0, 1, 1);
    xfer(32'h18, 0, 3'd3, NON_SEQ, 32'h0, 1, 1);
    xfer(32'h400, 1, 3'd2, NON_SEQ, 32'hFFFF_FFFF, 1, 1);
    xfer(32'h3FC, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);

    // Reset during a write data phase: the write must not land
    xfer(32'h30, 1, 3'd2, NON_SEQ, 32'h55AA55AA, 1, 0);
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    xfer(32'h30, 0, 3'd2, NON_SEQ, 32'h0, 1, 1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 32'h47F);
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      r  = $urandom_range(0, 9);
      tr = (r == 0) ? IDLE : (r == 1) ? BUSY : (r < 6) ? NON_SEQ : SEQ;
      HBURST = 3'($urandom_range(0, 7));
      xfer(a, 1'($urandom_range(0, 1)), sz, tr, $urandom, ($urandom_range(0, 9) != 0), 1);
    end

    HSEL   = 1'b0;
    HTRANS = IDLE;
    repeat (WS + 4) @(posedge HCLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d responses outstanding, required 0", exp_q.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
